// File: rtl/cc_unit_pkg.sv
// Shared Y86 encodings for the execute-stage condition-code unit:
// icodes, jXX/cmovXX condition functions and ALU functions.
package cc_unit_pkg;

  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/cc_unit_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation against a set of
// condition codes; undefined condition functions evaluate to false.
module cond_eval
  import cc_unit_pkg::*;
(
  input  logic       i_zf,
  input  logic       i_sf,
  input  logic       i_of,
  input  logic [3:0] i_ifun,
  output logic       o_cond
);

  logic w_lt;

  assign w_lt = i_sf ^ i_of;

  always_comb begin
    o_cond = 1'b0;
    case (i_ifun)
      C_YES:   o_cond = 1'b1;
      C_LE:    o_cond = w_lt | i_zf;
      C_L:     o_cond = w_lt;
      C_E:     o_cond = i_zf;
      C_NE:    o_cond = ~i_zf;
      C_GE:    o_cond = ~w_lt;
      C_G:     o_cond = ~w_lt & ~i_zf;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_unit.sv
// Execute-stage condition codes: ZF/SF/OF register updated by OPq,
// condition output for jXX/cmovXX, and saturating debug event counters.
module cc_unit
  import cc_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [63:0]      alu_out,
  input  logic             alu_of,
  input  logic             m_exc,
  input  logic             w_exc,
  input  logic             cnt_clr,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             e_cnd,
  output logic [CNT_W-1:0] cc_upd_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  cc_t              r_cc;
  logic [CNT_W-1:0] r_upd_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  logic w_set_cc;
  logic w_cond;
  logic w_is_cond_instr;
  logic w_mispred;
  logic w_arith;
  cc_t  w_cc_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // An OPq behind a faulting older instruction, or with an invalid ALU
  // function, must leave the architectural codes untouched.
  assign w_set_cc = e_valid & (e_icode == IOPQ) & ~m_exc & ~w_exc
                    & (e_ifun <= A_XOR);

  assign w_arith        = (e_ifun == A_ADD) | (e_ifun == A_SUB);
  assign w_cc_next.zf   = (alu_out == 64'd0);
  assign w_cc_next.sf   = alu_out[63];
  assign w_cc_next.of   = w_arith & alu_of;

  cond_eval u_cond_eval (
    .i_zf   (r_cc.zf),
    .i_sf   (r_cc.sf),
    .i_of   (r_cc.of),
    .i_ifun (e_ifun),
    .o_cond (w_cond)
  );

  assign w_is_cond_instr = e_valid & ((e_icode == IJXX) | (e_icode == IRRMOVQ));
  assign e_cnd           = w_is_cond_instr & w_cond;
  assign w_mispred       = e_valid & (e_icode == IJXX) & ~e_cnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
    end else if (w_set_cc) begin
      r_cc <= w_cc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_cnt <= '0;
      r_mis_cnt <= '0;
    end else if (cnt_clr) begin
      r_upd_cnt <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_set_cc)  r_upd_cnt <= sat_inc(r_upd_cnt);
      if (w_mispred) r_mis_cnt <= sat_inc(r_mis_cnt);
    end
  end

  assign zf          = r_cc.zf;
  assign sf          = r_cc.sf;
  assign of          = r_cc.of;
  assign cc_upd_cnt  = r_upd_cnt;
  assign mispred_cnt = r_mis_cnt;

endmodule
